alu_arbiter: RTL and testbench

Shares one instance of the team's 4-bit add/subtract `alu` between two requesters (port 0, port 1) with round-robin arbitration. It uses valid/ready handshakes on both request and response sides. Operands and opcode are captured on grant, the ALU is evaluated, and the 8-bit result is registered and held until the consumer accepts it. It sits between the switch/button front-end and the display path in the lab top level.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu.sv | 21 ++
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter: widths, opcodes,
// FSM encoding, latched request payload and the opcode legality check.
package alu_pkg;

  localparam int unsigned OW  = 4;  // operand width
  localparam int unsigned DW  = 8;  // result width
  localparam int unsigned CW  = 2;  // opcode width

  localparam logic [CW-1:0] OP_ADD = 2'b00;
  localparam logic [CW-1:0] OP_SUB = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic          id;
    logic [CW-1:0] op;
    logic [OW-1:0] a;
    logic [OW-1:0] b;
  } req_t;

  function automatic logic op_legal(input logic [CW-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu.sv
// 4-bit add/subtract unit with an 8-bit result; illegal opcodes yield zero.
module alu
  import alu_pkg::*;
(
  input  logic [OW-1:0] a,
  input  logic [OW-1:0] b,
  input  logic [CW-1:0] ctrl,
  output logic [DW-1:0] result
);

  // Add is zero-extended; subtract wraps in 8-bit two's complement.
  always_comb begin
    result = '0;
    case (ctrl)
      OP_ADD:  result = DW'(a) + DW'(b);
      OP_SUB:  result = DW'(a) - DW'(b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu between two valid/ready requesters, with a
// registered response held until the consumer accepts it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*OW-1:0] req_a,
  input  logic [NREQ*OW-1:0] req_b,
  input  logic [NREQ*CW-1:0] req_op,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_id,
  output logic               rsp_err,
  output logic               busy
);

  state_t        state, state_d;
  logic          prio, prio_d;
  req_t          lat, lat_d;
  logic          rsp_valid_d;
  logic [DW-1:0] rsp_data_d;
  logic          rsp_id_d;
  logic          rsp_err_d;
  logic          busy_d;
  logic          gnt_id;
  logic          any_req;
  logic [DW-1:0] alu_result;

  // Single requester wins outright; a tie goes to the port named by prio.
  always_comb begin
    any_req = |req_valid;
    if (req_valid[0] && req_valid[1]) gnt_id = prio;
    else                              gnt_id = req_valid[1];
  end

  alu u_alu (
    .a      (lat.a),
    .b      (lat.b),
    .ctrl   (lat.op),
    .result (alu_result)
  );

  always_comb begin
    state_d     = state;
    prio_d      = prio;
    lat_d       = lat;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_id_d    = rsp_id;
    rsp_err_d   = rsp_err;
    req_ready   = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready[gnt_id] = 1'b1;
          lat_d.id = gnt_id;
          lat_d.a  = gnt_id ? req_a[7:4]  : req_a[3:0];
          lat_d.b  = gnt_id ? req_b[7:4]  : req_b[3:0];
          lat_d.op = gnt_id ? req_op[3:2] : req_op[1:0];
          prio_d   = ~gnt_id;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = op_legal(lat.op) ? alu_result : '0;
        rsp_err_d   = ~op_legal(lat.op);
        rsp_id_d    = lat.id;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      lat       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      prio      <= prio_d;
      lat       <= lat_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_id    <= rsp_id_d;
      rsp_err   <= rsp_err_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, scoreboard monitor and hand-written
// sequences for fairness, backpressure and mid-operation reset.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [7:0] req_a, req_b;
  logic [3:0] req_op;
  logic [1:0] req_ready;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id, rsp_err, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       id;
    logic [8:0] res;
  } sb_t;
  sb_t  sb[$];
  logic grants[$];

  typedef struct {
    bit         port;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {err, data}
  function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return {1'b0, 8'(a) + 8'(b)};
      2'b01:   return {1'b0, 8'(a) - 8'(b)};
      default: return 9'h100;
    endcase
  endfunction

  // Monitor: push on request handshake, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_valid == 2'b11)
        check("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if ((req_valid & req_ready) != 2'b00) begin
        sb_t e;
        e.id  = req_ready[1];
        e.res = e.id ? model(req_a[7:4], req_b[7:4], req_op[3:2])
                     : model(req_a[3:0], req_b[3:0], req_op[1:0]);
        sb.push_back(e);
        grants.push_back(e.id);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_rsp", 32'(sb.size()), 32'd1);
        end else begin
          sb_t e;
          e = sb.pop_front();
          check("sb_data", 32'(rsp_data), 32'(e.res[7:0]));
          check("sb_id",   32'(rsp_id),   32'(e.id));
          check("sb_err",  32'(rsp_err),  32'(e.res[8]));
        end
      end
    end
  end

  task automatic drive(input bit port, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    if (port) begin
      req_a[7:4] = a; req_b[7:4] = b; req_op[3:2] = op;
    end else begin
      req_a[3:0] = a; req_b[3:0] = b; req_op[1:0] = op;
    end
    req_valid[port] = 1'b1;
  endtask

  // Raise a request, wait (bounded) for its grant, drop valid after the handshake.
  task automatic issue(input bit port, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    bit ok;
    logic [1:0] exp_rdy;
    ok = 1'b0;
    exp_rdy = port ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    drive(port, a, b, op);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin ok = 1'b1; break; end
    end
    check("grant_seen", 32'(ok), 32'd1);
    check("grant_port", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    req_valid[port] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    vecs[0] = '{1'b0, 4'hF, 4'hF, 2'b00, 8'h1E, 1'b0};
    vecs[1] = '{1'b1, 4'h3, 4'h5, 2'b01, 8'hFE, 1'b0};
    vecs[2] = '{1'b1, 4'h5, 4'h3, 2'b01, 8'h02, 1'b0};
    vecs[3] = '{1'b0, 4'h7, 4'h2, 2'b10, 8'h00, 1'b1};
    vecs[4] = '{1'b0, 4'h7, 4'h2, 2'b00, 8'h09, 1'b0};
    vecs[5] = '{1'b1, 4'h0, 4'h0, 2'b01, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 4'h0, 4'hF, 2'b01, 8'hF1, 1'b0};
    vecs[7] = '{1'b0, 4'h8, 4'h7, 2'b11, 8'h00, 1'b1};
    vecs[8] = '{1'b1, 4'hF, 4'h0, 2'b00, 8'h0F, 1'b0};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Vector table, back to back with rsp_ready high: IDLE, EXEC, RESP.
    rsp_ready = 1'b1;
    foreach (vecs[i]) begin
      issue(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op);
      @(negedge clk);
      check($sformatf("v%0d_exec_ready", i), 32'(req_ready), 32'd0);
      check($sformatf("v%0d_exec_valid", i), 32'(rsp_valid), 32'd0);
      check($sformatf("v%0d_exec_busy", i),  32'(busy),      32'd1);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("v%0d_data", i),  32'(rsp_data),  32'(vecs[i].exp_data));
      check($sformatf("v%0d_id", i),    32'(rsp_id),    32'(vecs[i].port));
      check($sformatf("v%0d_err", i),   32'(rsp_err),   32'(vecs[i].exp_err));
    end

    // Fairness: both ports held valid for six operations.
    @(posedge clk); #1;
    grants.delete();
    drive(1'b0, 4'h1, 4'h2, 2'b00);
    drive(1'b1, 4'h4, 4'h1, 2'b01);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (grants.size() >= 6) begin ok = 1'b1; break; end
    end
    req_valid = 2'b00;
    check("fair_done", 32'(ok), 32'd1);
    for (int i = 0; i < 6; i++)
      check($sformatf("fair_grant%0d", i), (i < grants.size()) ? 32'(grants[i]) : 32'd2, 32'(i % 2));
    repeat (4) @(negedge clk);

    // Backpressure: response held for 5 cycles while port 0 waits.
    rsp_ready = 1'b0;
    issue(1'b1, 4'h9, 4'h4, 2'b01);
    drive(1'b0, 4'h6, 4'h7, 2'b00);
    @(negedge clk);
    check("bp_exec_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d_data", i),  32'(rsp_data),  32'h05);
      check($sformatf("bp%0d_id", i),    32'(rsp_id),    32'd1);
      check($sformatf("bp%0d_err", i),   32'(rsp_err),   32'd0);
      check($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("bp_after_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_data", 32'(rsp_data), 32'h0D);
    check("bp_next_id",   32'(rsp_id),   32'd0);

    // Reset in EXEC: outputs clear at once, prio returns to 0.
    issue(1'b0, 4'h1, 4'h1, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_rsp_data",  32'(rsp_data),  32'd0);
    check("arst_rsp_id",    32'(rsp_id),    32'd0);
    check("arst_rsp_err",   32'(rsp_err),   32'd0);
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("arst_idle%0d_valid", i), 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    drive(1'b0, 4'h2, 4'h2, 2'b00);
    drive(1'b1, 4'h2, 4'h1, 2'b01);
    @(negedge clk);
    check("arst_prio_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(negedge clk);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
